am_envelope_detector: RTL and testbench

//   Receive-side counterpart of the AM modulator: recovers the Q1.15 envelope from
//   a signed 16-bit AM sample stream (y = x*env) by full-wave rectification and

---
 rtl/am_envelope_detector.sv | 133 +++++++++++++
 tb/tb_am_envelope_detector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_envelope_detector.sv
// am_envelope_detector
//   Recovers the Q1.15 envelope of a signed AM sample stream by full-wave
//   rectification followed by peak tracking. A new peak (or an equal one)
//   reloads a hold counter, and the envelope does not decay while that counter
//   is nonzero. Once the counter expires, the envelope decays exponentially
//   toward zero, with a minimum step of one LSB.
//   Hold and decay advance per valid sample, not per clock.
//   Optional feature macro: AM_ENV_SMOOTH_EN adds an EMA smoothing stage
//   (latency 3 instead of 2).
module am_envelope_detector #(
   parameter int DATA_W       = 16,
   parameter int HOLD_SAMPLES = 64,
   parameter int DECAY_SHIFT  = 6
`ifdef AM_ENV_SMOOTH_EN
   ,
   parameter int SMOOTH_SHIFT = 3
`endif
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_x,
   input  logic                     i_clear,
   output logic                     o_valid,
   output logic        [DATA_W-1:0] o_env_q15,
   output logic                     o_holding
);

   localparam int MAG_W  = DATA_W - 1;
   localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   // |x| on MAG_W bits; the most negative input saturates to full scale
   function automatic logic [MAG_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
      logic [DATA_W-1:0] neg;
      if (!x[DATA_W-1]) return x[MAG_W-1:0];
      neg = -x;
      if (neg[DATA_W-1]) return {MAG_W{1'b1}};
      return neg[MAG_W-1:0];
   endfunction

   // One decay step: env - max(env >> DECAY_SHIFT, 1), floored at zero
   function automatic logic [MAG_W-1:0] decay_step(input logic [MAG_W-1:0] env);
      logic [MAG_W-1:0] step;
      step = env >> DECAY_SHIFT;
      if (step == '0) step = {{(MAG_W-1){1'b0}}, 1'b1};
      if (env <= step) return '0;
      return env - step;
   endfunction

`ifdef AM_ENV_SMOOTH_EN
   // EMA update s + ((env - s) >>> SMOOTH_SHIFT) on an 18-bit signed difference
   function automatic logic [MAG_W-1:0] smooth_step(input logic [MAG_W-1:0] s,
                                                    input logic [MAG_W-1:0] env);
      logic signed [MAG_W+2:0] diff;
      logic signed [MAG_W+2:0] sum;
      diff = $signed({3'b000, env}) - $signed({3'b000, s});
      sum  = $signed({3'b000, s}) + (diff >>> SMOOTH_SHIFT);
      return sum[MAG_W-1:0];
   endfunction
`endif

   logic             vld_p1;
   logic [MAG_W-1:0] mag_p1;
   logic             vld_p2;
   logic [MAG_W-1:0] env_p2;
   logic [HOLD_W-1:0] hold_p2;

   // Stage 1 valid: accept a sample unless a clear discards it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= i_valid & ~i_clear;
   end

   // Stage 1 data: full-wave rectification
   always_ff @(posedge clk) begin
      if (i_valid) mag_p1 <= abs_sat(i_x);
   end

   // Stage 2: peak tracking with hold-then-decay, advanced only on stage-1 valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2  <= 1'b0;
         env_p2  <= '0;
         hold_p2 <= '0;
      end else if (i_clear) begin
         vld_p2  <= 1'b0;
         env_p2  <= '0;
         hold_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            if (mag_p1 >= env_p2) begin
               env_p2  <= mag_p1;
               hold_p2 <= HOLD_LOAD;
            end else if (hold_p2 != '0) begin
               hold_p2 <= hold_p2 - HOLD_ONE;
            end else if (env_p2 != '0) begin
               env_p2 <= decay_step(env_p2);
            end
         end
      end
   end

   assign o_holding = (hold_p2 != '0);

`ifdef AM_ENV_SMOOTH_EN
   logic             vld_p3;
   logic [MAG_W-1:0] s_p3;

   // Stage 3: exponential smoothing of the tracked envelope
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p3 <= 1'b0;
         s_p3   <= '0;
      end else if (i_clear) begin
         vld_p3 <= 1'b0;
         s_p3   <= '0;
      end else begin
         vld_p3 <= vld_p2;
         if (vld_p2) s_p3 <= smooth_step(s_p3, env_p2);
      end
   end

   assign o_valid   = vld_p3;
   assign o_env_q15 = {1'b0, s_p3};
`else
   assign o_valid   = vld_p2;
   assign o_env_q15 = {1'b0, env_p2};
`endif

endmodule

// File: tb/tb_am_envelope_detector.sv
// Testbench for am_envelope_detector: directed scenarios plus a randomized
// stream, all compared against a sample-level reference model.
module tb_am_envelope_detector;

   localparam int HOLD = 64;
`ifdef AM_ENV_SMOOTH_EN
   localparam int LAT_EDGES = 2;
`else
   localparam int LAT_EDGES = 1;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               i_valid = 1'b0;
   logic               i_clear = 1'b0;
   logic signed [15:0] i_x = '0;
   logic               o_valid;
   logic               o_holding;
   logic        [15:0] o_env_q15;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model state: samples waiting to reach the tracker, envelope,
   // hold count, smoothed value
   int pend_mag[$];
   int pend_due[$];
   int m_env = 0;
   int m_hold = 0;
   int m_s = 0;
   bit exp_valid = 1'b0;
   int outs[$];

   always #5 clk = ~clk;

   am_envelope_detector dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .i_x       (i_x),
      .i_clear   (i_clear),
      .o_valid   (o_valid),
      .o_env_q15 (o_env_q15),
      .o_holding (o_holding)
   );

   function automatic int mag_of(int x);
      if (x == -32768) return 32767;
      return (x < 0) ? -x : x;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      pend_mag.delete();
      pend_due.delete();
      m_env = 0;
      m_hold = 0;
      m_s = 0;
   endtask

   // One sample reaching the tracker, expressed directly from the envelope rules
   task automatic model_apply(int mag);
      int d;
      if (mag >= m_env) begin
         m_env = mag;
         m_hold = HOLD;
      end else if (m_hold > 0) begin
         m_hold = m_hold - 1;
      end else if (m_env > 0) begin
         d = m_env / 64;
         if (d < 1) d = 1;
         m_env = (m_env > d) ? m_env - d : 0;
      end
      m_s = m_s + ((m_env - m_s) >>> 3);
   endtask

   function automatic int model_out();
`ifdef AM_ENV_SMOOTH_EN
      return m_s;
`else
      return m_env;
`endif
   endfunction

   // Drive one clock of inputs, advance the model, compare outputs after the edge
   task automatic step(bit v, int x, bit clr);
      int mg;
      i_valid = v;
      i_x = x[15:0];
      i_clear = clr;
      @(posedge clk);
      cyc++;
      exp_valid = 1'b0;
      if (clr) begin
         model_zero();
      end else begin
         if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            mg = pend_mag.pop_front();
            void'(pend_due.pop_front());
            model_apply(mg);
            exp_valid = 1'b1;
         end
         if (v) begin
            pend_mag.push_back(mag_of(x));
            pend_due.push_back(cyc + LAT_EDGES);
         end
      end
      #1;
      check("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
      check("o_env", {16'd0, o_env_q15}, model_out());
`ifndef AM_ENV_SMOOTH_EN
      check("o_holding", {31'd0, o_holding}, (m_hold != 0) ? 1 : 0);
`endif
      if (o_valid === 1'b1) outs.push_back(int'(o_env_q15));
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      i_valid = 1'b0;
      i_clear = 1'b0;
      #1;
      check("rst_o_valid", {31'd0, o_valid}, 0);
      check("rst_o_env", {16'd0, o_env_q15}, 0);
      check("rst_o_holding", {31'd0, o_holding}, 0);
      model_zero();
      @(posedge clk);
      cyc++;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int r;
      int x;
      bit v;
      bit c;

      // power-on reset state
      #12;
      check("por_o_valid", {31'd0, o_valid}, 0);
      check("por_o_env", {16'd0, o_env_q15}, 0);
      check("por_o_holding", {31'd0, o_holding}, 0);
      @(posedge clk);
      cyc++;
      #2;
      rst_n = 1'b1;

      // single negative sample, latency and magnitude
      step(0, 0, 0);
      step(1, -16384, 0);
      step(0, 0, 0);
`ifndef AM_ENV_SMOOTH_EN
      check("t2_valid_at_lat2", {31'd0, o_valid}, 1);
      check("t2_env", {16'd0, o_env_q15}, 16384);
      check("t2_holding", {31'd0, o_holding}, 1);
`endif
      step(0, 0, 0);
      step(0, 0, 0);

      // most negative input saturates; equal-magnitude positive reloads hold
      step(1, -32768, 0);
      step(1, 32767, 0);
      step(0, 0, 0);
      step(0, 0, 0);
`ifndef AM_ENV_SMOOTH_EN
      check("t3_env_sat", {16'd0, o_env_q15}, 32767);
`endif

      // hold for 64 samples then exponential decay
      step(0, 0, 1);
      outs.delete();
      step(1, 16384, 0);
      for (int i = 0; i < 67; i++) step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
`ifndef AM_ENV_SMOOTH_EN
      check("t4_count", outs.size(), 68);
      check("t4_last_hold", outs[64], 16384);
      check("t4_decay1", outs[65], 16128);
      check("t4_decay2", outs[66], 15876);
`endif

      // minimum decay step of one LSB and floor at zero
      step(0, 0, 1);
      outs.delete();
      step(1, 5, 0);
      for (int i = 0; i < 70; i++) step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
`ifndef AM_ENV_SMOOTH_EN
      check("t5_d1", outs[65], 4);
      check("t5_d2", outs[66], 3);
      check("t5_d3", outs[67], 2);
      check("t5_d4", outs[68], 1);
      check("t5_d5", outs[69], 0);
      check("t5_d6", outs[70], 0);
`endif

      // clear with a sample in the same cycle and a full pipe
      step(1, 1000, 0);
      step(1, 2000, 0);
      step(1, 3000, 0);
      outs.delete();
      step(1, -20000, 1);
      check("t6_env_after_clear", {16'd0, o_env_q15}, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check("t6_no_outputs", outs.size(), 0);

`ifdef AM_ENV_SMOOTH_EN
      // smoothing response to a step from 0 to 16384
      outs.delete();
      step(1, 16384, 0);
      step(1, 16384, 0);
      step(1, 16384, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check("t6s_count", outs.size(), 3);
      check("t6s_o1", outs[0], 2048);
      check("t6s_o2", outs[1], 3840);
      check("t6s_o3", outs[2], 5408);
`endif

      // randomized stream with occasional clears and one mid-stream reset
      for (int i = 0; i < 2500; i++) begin
         v = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 9);
         if (r < 5) x = 0;
         else if (r < 8) x = int'($urandom_range(0, 600)) - 300;
         else if (r == 8) x = int'($urandom_range(0, 65535)) - 32768;
         else x = ($urandom_range(0, 1) == 1) ? -32768 : 32767;
         c = ($urandom_range(0, 199) == 0);
         if (i == 1200) begin
            step(1, 12345, 0);
            async_reset();
         end
         step(v, x, c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
